// File: rtl/fc_pkg.sv
// Shared state encoding and width derivations for the fully-connected tile buffers,
// so fc_ibuf and fc_obuf agree on every derived width.
package fc_pkg;

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} fc_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned psum_width(input int unsigned data_size,
                                             input int unsigned xbar_size);
    return data_size + $clog2(xbar_size);
  endfunction

  function automatic int unsigned obuf_data_size(input int unsigned data_size,
                                                 input int unsigned xbar_size);
    return 2 * data_size + $clog2(xbar_size);
  endfunction

  function automatic int unsigned num_channels(input int unsigned data_size,
                                               input int unsigned xbar_size,
                                               input int unsigned bus_width);
    return bus_width / obuf_data_size(data_size, xbar_size);
  endfunction

  function automatic int unsigned fifo_length(input int unsigned data_size,
                                              input int unsigned xbar_size,
                                              input int unsigned bus_width);
    int unsigned ne;
    int unsigned nc;
    ne = xbar_size / data_size;
    nc = num_channels(data_size, xbar_size, bus_width);
    return (ne + nc - 1) / nc;
  endfunction

endpackage

// File: rtl/fc_obuf_acc.sv
// One output element's shift-add accumulator: adds a sign-extended bit-plane
// partial sum weighted by 2^bit_cnt.
module fc_obuf_acc
  import fc_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = 15,
  parameter int unsigned ACC_WIDTH  = 23,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [CNT_WIDTH-1:0]         bit_cnt,
  input  logic signed [PSUM_WIDTH-1:0] psum,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, term;

  always_comb begin
    term  = {{(ACC_WIDTH - PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum} <<< bit_cnt;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_obuf.sv
// Output buffer for one FC CIM tile: shift-adds bit-serial partial sums, then drains
// NUM_CHANNELS results per beat. Define FC_OBUF_RELU_EN to clamp negative outputs to 0.
module fc_obuf
  import fc_pkg::*;
#(
  parameter int unsigned  DATA_SIZE      = 8,
  parameter int unsigned  XBAR_SIZE      = 128,
  parameter int unsigned  OBUF_BUS_WIDTH = 46,
  localparam int unsigned PSUM_WIDTH     = psum_width(DATA_SIZE, XBAR_SIZE),
  localparam int unsigned OBUF_DATA_SIZE = obuf_data_size(DATA_SIZE, XBAR_SIZE),
  localparam int unsigned NUM_ELEMS      = XBAR_SIZE / DATA_SIZE,
  localparam int unsigned NUM_CHANNELS   = num_channels(DATA_SIZE, XBAR_SIZE, OBUF_BUS_WIDTH),
  localparam int unsigned FIFO_LENGTH    = fifo_length(DATA_SIZE, XBAR_SIZE, OBUF_BUS_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_psum_valid,
  input  logic signed [PSUM_WIDTH-1:0]     i_psum [NUM_ELEMS],
  output logic        [OBUF_DATA_SIZE-1:0] o_data [NUM_CHANNELS],
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int unsigned CntW  = clog2_min1(DATA_SIZE);
  localparam int unsigned BeatW = clog2_min1(FIFO_LENGTH);
  localparam int unsigned ElemW = clog2_min1(NUM_ELEMS);

  fc_state_e         state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              done_q, done_d;
  logic              acc_clr, acc_en;
  int unsigned       elem_idx [NUM_CHANNELS];

  logic signed [OBUF_DATA_SIZE-1:0] acc [NUM_ELEMS];

  for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_acc
    fc_obuf_acc #(
      .PSUM_WIDTH(PSUM_WIDTH),
      .ACC_WIDTH (OBUF_DATA_SIZE),
      .CNT_WIDTH (CntW)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .en     (acc_en),
      .bit_cnt(bit_cnt_q),
      .psum   (i_psum[e]),
      .acc    (acc[e])
    );
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          acc_clr   = 1'b1;
          bit_cnt_d = '0;
          state_d   = StAcc;
        end
      end
      StAcc: begin
        if (i_psum_valid) begin
          acc_en = 1'b1;
          if (bit_cnt_q == CntW'(DATA_SIZE - 1)) begin
            bit_cnt_d = '0;
            beat_d    = '0;
            state_d   = StDrain;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        if (i_ready) begin
          if (beat_q == BeatW'(FIFO_LENGTH - 1)) begin
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
    end
  end

  assign o_valid = (state_q == StDrain);
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;

  // Channels past the last element (ragged final beat) and all idle cycles read as 0.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      elem_idx[c] = 32'(beat_q) * NUM_CHANNELS + c;
      o_data[c]   = '0;
      if (o_valid && (elem_idx[c] < NUM_ELEMS)) begin
        o_data[c] = acc[ElemW'(elem_idx[c])];
      end
`ifdef FC_OBUF_RELU_EN
      if (o_data[c][OBUF_DATA_SIZE-1]) begin
        o_data[c] = '0;
      end
`endif
    end
  end

endmodule
